// File: rtl/float_accum_if.sv
// Operand/result stream bundle for the mini-float accumulator.
// The master drives operands, clear and out_ready; the slave returns results.
interface float_accum_if #(
    parameter int unsigned CNT_W = 5
);
    localparam int unsigned DATA_W = 8;

    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_sat;
    logic [CNT_W-1:0]  out_count;

    modport master (
        output clear, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_count
    );

    modport slave (
        input  clear, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_count
    );
endinterface

// File: rtl/float_accum.sv
// Frame accumulator for unsigned 8-bit mini-floats {E[2:0], M[4:0]}, value M*2^E.
// Folds accepted operands into a running sum and emits one result per frame.
module float_accum #(
    parameter int unsigned MAX_SAMPLES = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    float_accum_if.slave  bus
);
    localparam int unsigned DATA_W = 8;

    typedef enum logic [0:0] {ACCUM = 1'b0, DONE = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic [DATA_W-1:0]  odata_q, odata_d;
    logic [CNT_W-1:0]   ocnt_q, ocnt_d;
    logic               osat_q, osat_d;

    logic [DATA_W:0]    fsum;
    logic [CNT_W-1:0]   cnt_inc;
    logic               frame_end;

    // Returns {saturation_event, sum}: align the smaller exponent, add, renormalise once.
    function automatic logic [DATA_W:0] fadd(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
        logic [2:0] e_big, e_sml, d;
        logic [4:0] m_big, m_sml;
        logic [5:0] s;
        logic [DATA_W:0] r;
        if (a[7:5] >= b[7:5]) begin
            e_big = a[7:5]; m_big = a[4:0];
            e_sml = b[7:5]; m_sml = b[4:0];
        end else begin
            e_big = b[7:5]; m_big = b[4:0];
            e_sml = a[7:5]; m_sml = a[4:0];
        end
        d = e_big - e_sml;
        s = {1'b0, m_big} + {1'b0, m_sml >> d};
        if (!s[5])
            r = {1'b0, e_big, s[4:0]};
        else if (e_big != 3'd7)
            r = {1'b0, e_big + 3'd1, s[5:1]};
        else
            r = {1'b1, 8'hFF};
        return r;
    endfunction

    assign fsum      = fadd(acc_q, bus.in_data);
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign frame_end = bus.in_last | (cnt_inc == CNT_W'(MAX_SAMPLES));

    assign bus.in_ready  = (state_q == ACCUM) & ~bus.clear;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = odata_q;
    assign bus.out_sat   = osat_q;
    assign bus.out_count = ocnt_q;

    // Next-state and datapath updates; clear overrides both states.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        odata_d = odata_q;
        ocnt_d  = ocnt_q;
        osat_d  = osat_q;

        if (bus.clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc_d = fsum[DATA_W-1:0];
                        cnt_d = cnt_inc;
                        sat_d = sat_q | fsum[DATA_W];
                        if (frame_end) begin
                            state_d = DONE;
                            odata_d = fsum[DATA_W-1:0];
                            ocnt_d  = cnt_inc;
                            osat_d  = sat_q | fsum[DATA_W];
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        sat_d   = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            odata_q <= '0;
            ocnt_q  <= '0;
            osat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            odata_q <= odata_d;
            ocnt_q  <= ocnt_d;
            osat_q  <= osat_d;
        end
    end
endmodule

// File: tb/tb_float_accum.sv
// Bench for float_accum: directed frames with literal results, then random traffic
// checked every cycle against a frame-level model (operand queue folded at frame close).
module tb_float_accum;
    localparam int unsigned MAX_S = 4;
    localparam int unsigned CW    = 5;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    float_accum_if #(.CNT_W(CW)) bus ();

    float_accum #(.MAX_SAMPLES(MAX_S), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    endfunction

    // Float add by the value rule, using plain integers.
    function automatic int fadd_m(input int a, input int b, output bit ev);
        int ea, ma, eb, mb, ebig, mbig, msml, s;
        ea = a / 32; ma = a % 32;
        eb = b / 32; mb = b % 32;
        ev = 1'b0;
        if (ea >= eb) begin ebig = ea; mbig = ma; msml = mb >> (ea - eb); end
        else          begin ebig = eb; mbig = mb; msml = ma >> (eb - ea); end
        s = mbig + msml;
        if (s < 32) return ebig * 32 + s;
        if (ebig < 7) return (ebig + 1) * 32 + s / 2;
        ev = 1'b1;
        return 255;
    endfunction

    // Frame-level model
    int   frame_q[$];
    bit   pending;
    int   exp_data, exp_cnt;
    bit   exp_sat;

    initial begin
        pending = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                frame_q.delete(); pending = 1'b0;
            end else if (bus.clear) begin
                frame_q.delete(); pending = 1'b0;
            end else if (pending) begin
                if (bus.out_ready) pending = 1'b0;
            end else if (bus.in_valid) begin
                frame_q.push_back(int'(bus.in_data));
                if (bus.in_last || frame_q.size() == MAX_S) begin
                    int a; bit s, ev;
                    a = 0; s = 1'b0;
                    foreach (frame_q[i]) begin
                        a = fadd_m(a, frame_q[i], ev);
                        s = s | ev;
                    end
                    exp_data = a; exp_sat = s; exp_cnt = frame_q.size();
                    pending  = 1'b1;
                    frame_q.delete();
                end
            end
        end
    end

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("in_ready", int'(bus.in_ready), int'(!pending && !bus.clear));
                check("out_valid", int'(bus.out_valid), int'(pending));
                if (pending) begin
                    check("out_data", int'(bus.out_data), exp_data);
                    check("out_sat", int'(bus.out_sat), int'(exp_sat));
                    check("out_count", int'(bus.out_count), exp_cnt);
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int k;
        k = 0;
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = l;
        @(negedge clk);
        while (!bus.in_ready && k < 50) begin @(negedge clk); k++; end
        if (!bus.in_ready) check("send_timeout", 0, 1);
        @(posedge clk); #2;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
    endtask

    task automatic get_result(input string name, input int d, input int c, input int s);
        int k;
        k = 0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        while (!bus.out_valid && k < 50) begin @(negedge clk); k++; end
        check({name, "_valid"}, int'(bus.out_valid), 1);
        check({name, "_data"}, int'(bus.out_data), d);
        check({name, "_count"}, int'(bus.out_count), c);
        check({name, "_sat"}, int'(bus.out_sat), s);
        @(posedge clk); #2;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_out_valid"}, int'(bus.out_valid), 0);
        check({name, "_out_data"}, int'(bus.out_data), 0);
        check({name, "_out_count"}, int'(bus.out_count), 0);
        check({name, "_out_sat"}, int'(bus.out_sat), 0);
    endtask

    initial begin
        bit ev;
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0;
        bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
        bus.in_last = 1'b0; bus.out_ready = 1'b1;

        // Pin the model against hand-computed sums
        check("model_21_22", fadd_m(32'h21, 32'h22, ev), 32'h23);
        check("model_3f_21", fadd_m(32'h3F, 32'h21, ev), 32'h50);
        check("model_ff_e1", fadd_m(32'hFF, 32'hE1, ev), 32'hFF);
        check("model_ff_e1_ev", int'(ev), 1);
        check("model_83_27", fadd_m(32'h83, 32'h27, ev), 32'h83);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", int'(bus.in_ready), 1);
        @(posedge clk); #2;

        send(8'h21, 1'b0); send(8'h22, 1'b1);
        get_result("t1", 32'h23, 2, 0);
        send(8'h3F, 1'b0); send(8'h21, 1'b1);
        get_result("t2", 32'h50, 2, 0);
        send(8'hFF, 1'b0); send(8'hE1, 1'b0); send(8'h01, 1'b1);
        get_result("t3", 32'hFF, 3, 1);
        send(8'h83, 1'b0); send(8'h27, 1'b1);
        get_result("t4", 32'h83, 2, 0);

        // Result held while downstream stalls, incoming operand refused
        bus.out_ready = 1'b0;
        send(8'h21, 1'b0); send(8'h22, 1'b1);
        bus.in_valid = 1'b1; bus.in_data = 8'h33;
        repeat (3) begin
            @(negedge clk);
            check("t5_hold_valid", int'(bus.out_valid), 1);
            check("t5_hold_data", int'(bus.out_data), 32'h23);
            check("t5_hold_count", int'(bus.out_count), 2);
            check("t5_in_ready", int'(bus.in_ready), 0);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #2;
        @(negedge clk);
        check("t5_release_ready", int'(bus.in_ready), 1);
        check("t5_release_valid", int'(bus.out_valid), 0);
        @(posedge clk); #2;

        // Auto close at MAX_S samples
        repeat (4) send(8'h01, 1'b0);
        get_result("t6_max", 32'h04, 4, 0);

        // Clear with a coincident operand
        send(8'h01, 1'b0); send(8'h01, 1'b0);
        bus.clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h05;
        @(negedge clk);
        check("t6_clear_ready", int'(bus.in_ready), 0);
        @(posedge clk); #2;
        bus.clear = 1'b0; bus.in_valid = 1'b0;
        send(8'h21, 1'b1);
        get_result("t6_clear", 32'h21, 1, 0);

        // Async reset mid-frame
        send(8'h01, 1'b0); send(8'h02, 1'b0);
        rst_n = 1'b0; #1;
        check_reset_outputs("rst_mid");
        @(posedge clk); #2;
        rst_n = 1'b1;
        send(8'h21, 1'b1);
        get_result("after_rst_mid", 32'h21, 1, 0);

        // Async reset while a result is pending
        bus.out_ready = 1'b0;
        send(8'h42, 1'b1);
        @(negedge clk);
        check("rst_done_pre", int'(bus.out_valid), 1);
        rst_n = 1'b0; #1;
        check_reset_outputs("rst_done");
        @(posedge clk); #2;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #2;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom % 10) < 7;
            bus.in_data   = ($urandom % 2) ? 8'($urandom_range(0, 95)) : 8'($urandom);
            bus.in_last   = ($urandom % 6) == 0;
            bus.out_ready = ($urandom % 10) < 6;
            bus.clear     = ($urandom % 40) == 0;
            @(posedge clk); #2;
        end
        bus.in_valid = 1'b0; bus.clear = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
